// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Shared definitions for the stream multiplexer:
//   MODE_FIXED / MODE_RR  - values of the stream_mux `mode` input
//   MIN_CHANNELS / MAX_CHANNELS - supported channel-count range
//   IDX_W                 - index width able to address MAX_CHANNELS
//   onehot_to_idx()       - converts a one-hot vector (zero-padded to
//                           MAX_CHANNELS) into the index of its set bit
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MIN_CHANNELS = 2;
    localparam int MAX_CHANNELS = 16;
    localparam int IDX_W        = $clog2(MAX_CHANNELS);

    // OR-of-indices form: for a true one-hot input this is the index of the
    // set bit, and it maps to a shallow OR tree rather than a priority chain.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CHANNELS-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotate-priority arbiter. The highest priority belongs
// to channel `ptr`, then ptr+1, ... wrapping modulo CHANNELS.
// Ports:
//   req   [CHANNELS] in  - request vector
//   ptr   [SEL_W]    in  - channel holding highest priority (< CHANNELS)
//   grant [CHANNELS] out - one-hot grant, all zero when req is zero
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant
);

    // Two passes: first the channels at or above ptr, then the wrapped-around
    // channels below ptr. The second pass only fires when the first found
    // nothing, which is exactly the modulo search order.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// -----------------------------------------------------------------------------
// stream_mux
// N-channel valid/ready stream multiplexer with a single registered output
// stage. The source channel is chosen either by an external select (mode=0)
// or by fair round-robin arbitration (mode=1).
//
// Optional build macro STREAM_MUX_LOCK_EN: packet lock. Once a beat with
// in_last=0 is accepted, grant stays on that channel until its in_last=1 beat.
// Without the macro in_last is ignored and arbitration is per beat.
//
// Ports:
//   clk        in  - rising-edge clock
//   rst        in  - synchronous active-high reset
//   mode       in  - 0 fixed select, 1 round-robin
//   sel        in  [SEL_W]          - channel index in fixed mode
//   in_valid   in  [CHANNELS]       - per-channel valid
//   in_data    in  [CHANNELS*WIDTH] - channel i at [i*WIDTH +: WIDTH]
//   in_last    in  [CHANNELS]       - end-of-packet (lock build only)
//   in_ready   out [CHANNELS]       - per-channel accept (combinational)
//   out_valid  out                  - output register holds a beat
//   out_data   out [WIDTH]          - registered data
//   out_sel    out [SEL_W]          - channel that supplied out_data
//   out_ready  in                   - consumer accept
// -----------------------------------------------------------------------------
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    // ------------------------------------------------------------------
    // Grant generation
    // ------------------------------------------------------------------
    logic                load;
    logic [CHANNELS-1:0] grant_fixed;
    logic [CHANNELS-1:0] grant_rr;
    logic [CHANNELS-1:0] grant_mode;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] xfer_vec;
    logic                xfer;
    logic [SEL_W-1:0]    xfer_idx;
    logic [SEL_W-1:0]    xfer_idx_inc;
    logic                last_beat;

    // The register may take a new beat when it is empty or draining this cycle.
    assign load = !out_valid_q || out_ready;

    // An out-of-range sel matches no genvar, so it yields no grant.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_fixed
            assign grant_fixed[gi] = (sel == SEL_W'(gi)) && in_valid[gi];
        end
    endgenerate

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (grant_rr)
    );

    assign grant_mode = (mode == MODE_RR) ? grant_rr : grant_fixed;

`ifdef STREAM_MUX_LOCK_EN
    logic             lock_q,     lock_d;
    logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
    logic [CHANNELS-1:0] grant_lock;

    // While locked, only the locked channel may be granted; if it is idle
    // nobody else gets through.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lock
            assign grant_lock[gi] = (lock_idx_q == SEL_W'(gi)) && in_valid[gi];
        end
    endgenerate

    assign grant     = lock_q ? grant_lock : grant_mode;
    assign last_beat = |(xfer_vec & in_last);

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (xfer) begin
            lock_d     = !last_beat;
            lock_idx_d = xfer_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    logic unused_in_last;

    assign grant          = grant_mode;
    assign last_beat      = 1'b1;
    assign unused_in_last = ^in_last;
`endif

    // Gating with rst keeps producers from seeing a phantom accept while the
    // register is being cleared.
    assign in_ready = grant & {CHANNELS{load && !rst}};
    assign xfer_vec = in_ready & in_valid;
    assign xfer     = |xfer_vec;
    assign xfer_idx = SEL_W'(onehot_to_idx(MAX_CHANNELS'(xfer_vec)));

    assign xfer_idx_inc = (xfer_idx == SEL_W'(CHANNELS - 1)) ? '0 : xfer_idx + 1'b1;

    // ------------------------------------------------------------------
    // Data path: AND-OR mux driven by the one-hot transfer vector
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] slice_masked [CHANNELS];
    logic [WIDTH-1:0] mux_data;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slice
            assign slice_masked[gi] = in_data[gi*WIDTH +: WIDTH] & {WIDTH{xfer_vec[gi]}};
        end
    endgenerate

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mux_data = mux_data | slice_masked[i];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;

        if (load) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = mux_data;
            out_sel_d  = xfer_idx;
        end
        // Fairness pointer moves only for round-robin transfers, and in the
        // lock build only once the packet has finished.
        if (xfer && (mode == MODE_RR) && last_beat) begin
            ptr_d = xfer_idx_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
module tb_stream_mux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 3;   // wide enough to drive sel=5

    logic                      clk;
    logic                      rst;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_last;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    stream_mux #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
        $display("check %-14s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        int exp_seq [4];
        int ch0_beats;
        int exp_ch;

        // ---------------- reset with every channel requesting ----------------
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'b1111;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        in_data   = '0;
        for (int c = 0; c < CHANNELS; c++) set_ch(c, 8'h11 * (c + 1));
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data",  32'(out_data),  32'h0);
        check("rst_sel",   32'(out_sel),   32'h0);
        check("rst_ready", 32'(in_ready),  32'h0);

        // First transfer after release comes from channel 0.
        rst = 1'b0;
        #1;
        check("first_ready", 32'(in_ready), 32'h1);
        step();
        check("first_valid", 32'(out_valid), 32'h1);
        check("first_sel",   32'(out_sel),   32'h0);
        check("first_data",  32'(out_data),  32'h11);

        // ---------------- round-robin, all valid, one beat per cycle ---------
        for (int k = 1; k <= 5; k++) begin
            exp_ch = k % 4;
            check("rr_ready", 32'(in_ready), 32'(1 << exp_ch));
            step();
            check("rr_valid", 32'(out_valid), 32'h1);
            check("rr_sel",   32'(out_sel),   32'(exp_ch));
            check("rr_data",  32'(out_data),  32'(8'h11 * (exp_ch + 1)));
        end

        // ---------------- sparse: ch1 and ch3, ptr=2 -> 3,1,3 ----------------
        in_valid = 4'b1010;
        #1;
        check("sp_ready0", 32'(in_ready), 32'h8);
        step();
        check("sp_sel0", 32'(out_sel), 32'h3);
        check("sp_ready1", 32'(in_ready), 32'h2);
        step();
        check("sp_sel1", 32'(out_sel), 32'h1);
        check("sp_ready2", 32'(in_ready), 32'h8);
        step();
        check("sp_sel2",  32'(out_sel),  32'h3);
        check("sp_data2", 32'(out_data), 32'h44);

        // ---------------- fixed select ----------------
        mode     = 1'b0;
        sel      = 3'd2;
        in_valid = 4'b1111;
        set_ch(2, 8'hA5);
        #1;
        check("fx_ready", 32'(in_ready), 32'h4);
        step();
        check("fx_data", 32'(out_data), 32'hA5);
        check("fx_sel",  32'(out_sel),  32'h2);

        // Out-of-range select grants nothing.
        sel = 3'd5;
        #1;
        check("sel5_ready", 32'(in_ready), 32'h0);
        step();
        check("sel5_valid", 32'(out_valid), 32'h0);

        // ---------------- backpressure ----------------
        sel = 3'd2;
        set_ch(2, 8'h3C);
        #1;
        check("bp_ready_in", 32'(in_ready), 32'h4);
        step();
        check("bp_load", 32'(out_data), 32'h3C);
        out_ready = 1'b0;
        set_ch(2, 8'h5A);
        sel = 3'd1;             // select change while a beat is held
        #1;
        check("bp_ready0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_data",  32'(out_data),  32'h3C);
            check("bp_hold_valid", 32'(out_valid), 32'h1);
            check("bp_hold_sel",   32'(out_sel),   32'h2);
            check("bp_hold_ready", 32'(in_ready),  32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_ready", 32'(in_ready), 32'h2);
        step();
        check("bp_rel_data",  32'(out_data),  32'h22);
        check("bp_rel_sel",   32'(out_sel),   32'h1);
        check("bp_rel_valid", 32'(out_valid), 32'h1);

        // ---------------- ptr untouched by fixed-mode transfers ----------------
        mode = 1'b1;
        #1;
        check("rr_resume_rdy", 32'(in_ready), 32'h1);
        step();
        check("rr_resume_sel", 32'(out_sel), 32'h0);

        // ---------------- reset mid-operation drops the held beat ------------
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        check("mrst_valid", 32'(out_valid), 32'h0);
        check("mrst_data",  32'(out_data),  32'h0);
        check("mrst_sel",   32'(out_sel),   32'h0);
        rst = 1'b0;
        #1;
        check("mrst_ready", 32'(in_ready), 32'h1);

        // ---------------- packet lock / per-beat alternation ----------------
`ifdef STREAM_MUX_LOCK_EN
        exp_seq = '{0, 0, 0, 1};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        out_ready = 1'b1;
        in_valid  = 4'b0011;
        ch0_beats = 0;
        for (int k = 0; k < 4; k++) begin
            in_last = {3'b001, (ch0_beats == 2)};
            step();
            check("lock_sel", 32'(out_sel), 32'(exp_seq[k]));
            if (exp_seq[k] == 0) ch0_beats++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
